// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and DMA-bus-side signal bundle for the OAM DMA controller.
// slave: the controller itself; master: the surrounding CPU/bus fabric.
interface oam_dma_ctrl_if;
    logic [15:0] CPU_ADDR;
    logic [7:0]  CPU_DATA_OUT;
    logic        CPU_RW_n;
    logic        CPU_RDY;
    logic        BUS_OWNER;
    logic [15:0] BUS_ADDR;
    logic        BUS_RW_n;
    logic [7:0]  BUS_DATA_IN;
    logic [7:0]  BUS_DATA_OUT;
    logic        DMA_ACTIVE;
    logic        DMA_DONE;

    modport slave (
        input  CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, BUS_DATA_IN,
        output CPU_RDY, BUS_OWNER, BUS_ADDR, BUS_RW_n, BUS_DATA_OUT,
               DMA_ACTIVE, DMA_DONE
    );

    modport master (
        output CPU_ADDR, CPU_DATA_OUT, CPU_RW_n, BUS_DATA_IN,
        input  CPU_RDY, BUS_OWNER, BUS_ADDR, BUS_RW_n, BUS_DATA_OUT,
               DMA_ACTIVE, DMA_DONE
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to DMA_REG_ADDR stalls the CPU and copies
// page P ($P00-$PFF) byte by byte into OAMDATA_ADDR, read/write interleaved.
// Optional macro OAM_DMA_ALIGN_EN adds the parity flop and the ALIGN state,
// giving an extra stall cycle when the DMA starts on an odd cycle.
module oam_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter logic [15:0] OAMDATA_ADDR = 16'h2004,
    parameter int          XFER_LEN     = 256
) (
    input  logic               CLK,
    input  logic               RESET_n,
    oam_dma_ctrl_if.slave      bus
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_page;
    logic [7:0] r_idx;
    logic [7:0] r_latch;
    logic       w_trigger;

    assign w_trigger = (r_state == ST_IDLE) && !bus.CPU_RW_n &&
                       (bus.CPU_ADDR == DMA_REG_ADDR);

`ifdef OAM_DMA_ALIGN_EN
    logic r_parity;

    // Free-running cycle parity, decides whether HALT needs an ALIGN cycle.
    always_ff @(posedge CLK) begin
        if (!RESET_n) r_parity <= 1'b0;
        else          r_parity <= ~r_parity;
    end
`endif

    // State register; reset drops straight to IDLE so the bus returns at once.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!RESET_n) r_state <= ST_IDLE;
        else          r_state <= w_next_state;
    end

    // Datapath: page capture on trigger, byte latch on READ, index on WRITE.
    always_ff @(posedge CLK) begin
        // NOTE: synchronous reset is applied to every datapath flop here,
        // since reset must leave page, index and latch at zero.
        if (!RESET_n) begin
            r_page  <= 8'h00;
            r_idx   <= 8'h00;
            r_latch <= 8'h00;
        end else begin
            if (w_trigger)             r_page  <= bus.CPU_DATA_OUT;
            if (r_state == ST_READ)    r_latch <= bus.BUS_DATA_IN;
            if (r_state == ST_WRITE)   r_idx   <= r_idx + 8'd1;
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default assignment first so no path through the case can
        // leave the signal unassigned and infer a latch.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_trigger) w_next_state = ST_HALT;
`ifdef OAM_DMA_ALIGN_EN
            ST_HALT:  w_next_state = r_parity ? ST_ALIGN : ST_READ;
            ST_ALIGN: w_next_state = ST_READ;
`else
            ST_HALT:  w_next_state = ST_READ;
`endif
            ST_READ:  w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = (r_idx == LAST_IDX) ? ST_DONE : ST_READ;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Latched byte is always presented; it only matters while BUS_RW_n=0.
    assign bus.BUS_DATA_OUT = r_latch;

    // Output decode from the current state.
    always_comb begin
        bus.CPU_RDY    = 1'b1;
        bus.BUS_OWNER  = 1'b0;
        bus.BUS_ADDR   = 16'h0000;
        bus.BUS_RW_n   = 1'b1;
        bus.DMA_ACTIVE = 1'b0;
        bus.DMA_DONE   = 1'b0;
        case (r_state)
            ST_HALT, ST_ALIGN: begin
                bus.CPU_RDY    = 1'b0;
                bus.BUS_OWNER  = 1'b1;
                bus.DMA_ACTIVE = 1'b1;
            end
            ST_READ: begin
                bus.CPU_RDY    = 1'b0;
                bus.BUS_OWNER  = 1'b1;
                bus.DMA_ACTIVE = 1'b1;
                bus.BUS_ADDR   = {r_page, r_idx};
            end
            ST_WRITE: begin
                bus.CPU_RDY    = 1'b0;
                bus.BUS_OWNER  = 1'b1;
                bus.DMA_ACTIVE = 1'b1;
                bus.BUS_ADDR   = OAMDATA_ADDR;
                bus.BUS_RW_n   = 1'b0;
            end
            ST_DONE:  bus.DMA_DONE = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Self-checking bench for oam_dma_ctrl: random RAM contents and pages,
// transfers checked against a transaction-level model of the copy.
module tb_oam_dma_ctrl;

    localparam logic [15:0] DMA_REG = 16'h4014;
    localparam logic [15:0] OAMDATA = 16'h2004;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt   = 0;   // edges since reset release: cycle parity reference
    logic [7:0] mem [65536];

    always #5 clk = ~clk;

    oam_dma_ctrl_if u_if ();

    oam_dma_ctrl u_dut (
        .CLK     (clk),
        .RESET_n (rst_n),
        .bus     (u_if)
    );

    assign u_if.BUS_DATA_IN = mem[u_if.BUS_ADDR];

    always @(posedge clk) begin
        if (!rst_n) cnt <= 0;
        else        cnt <= cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_bus();
        u_if.CPU_RW_n     = 1'b1;
        u_if.CPU_ADDR     = 16'h8000 | 16'($urandom_range(0, 16'h3FFF));
        u_if.CPU_DATA_OUT = 8'($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rdy"},    u_if.CPU_RDY,    1'b1);
        check({tag, "_owner"},  u_if.BUS_OWNER,  1'b0);
        check({tag, "_active"}, u_if.DMA_ACTIVE, 1'b0);
        check({tag, "_done"},   u_if.DMA_DONE,   1'b0);
    endtask

    // One DMA from trigger to return to IDLE. inject_at >= 0 issues a
    // second trigger ($07) while writing that index; reset_at >= 0 resets
    // while reading that index and returns early.
    task automatic run_dma(input logic [7:0] page, input bit halt_par,
                           input int inject_at, input int reset_at);
        int         k;
        int         stall;
        int         dones;
        int         exp_stall;
        bit         par_at_halt;
        bit         finished;
        bit         do_inj;
        logic [15:0] prev_addr;
        logic [7:0]  last_wdata;
        logic [15:0] rd_a;

        while (((cnt + 1) & 1) != int'(halt_par)) @(negedge clk);
        u_if.CPU_ADDR     = DMA_REG;
        u_if.CPU_RW_n     = 1'b0;
        u_if.CPU_DATA_OUT = page;
        @(negedge clk);
        idle_bus();
        par_at_halt = cnt[0];
`ifdef OAM_DMA_ALIGN_EN
        exp_stall = 513 + int'(par_at_halt);
`else
        exp_stall = 513;
`endif
        check("halt_rdy",    u_if.CPU_RDY,    1'b0);
        check("halt_owner",  u_if.BUS_OWNER,  1'b1);
        check("halt_active", u_if.DMA_ACTIVE, 1'b1);
        check("halt_rw",     u_if.BUS_RW_n,   1'b1);

        k = 0; stall = 0; dones = 0; finished = 0; do_inj = 0;
        prev_addr = 16'h0; last_wdata = 8'h0;
        for (int cyc = 0; cyc < 700 && !finished; cyc++) begin
            if (dones > 0 && !u_if.DMA_DONE) begin
                check_idle_outputs("post_done");
                check("hold_data", u_if.BUS_DATA_OUT, mem[{page, 8'hFF}]);
                finished = 1;
            end
            if (!u_if.CPU_RDY) stall++;
            if (!u_if.CPU_RDY) check("owner_compl", u_if.BUS_OWNER, 1'b1);
            if (u_if.BUS_OWNER && !u_if.BUS_RW_n) begin
                rd_a = {page, 8'(k)};
                check("wr_addr", u_if.BUS_ADDR, OAMDATA);
                check("wr_data", u_if.BUS_DATA_OUT, mem[rd_a]);
                check("rd_addr", prev_addr, rd_a);
                last_wdata = u_if.BUS_DATA_OUT;
                if (k == inject_at) do_inj = 1;
                k++;
            end
            if (u_if.DMA_DONE) begin
                dones++;
                check("done_rdy",   u_if.CPU_RDY,   1'b1);
                check("done_owner", u_if.BUS_OWNER, 1'b0);
            end
            if (reset_at >= 0 && k == reset_at && u_if.BUS_OWNER && u_if.BUS_RW_n &&
                u_if.BUS_ADDR == {page, 8'(reset_at)}) begin
                rst_n = 1'b0;
                @(negedge clk);
                check_idle_outputs("rst_mid");
                check("rst_mid_addr", u_if.BUS_ADDR, 16'h0000);
                check("rst_mid_wdata", u_if.BUS_DATA_OUT, 8'h00);
                rst_n = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("rst_no_done", u_if.DMA_DONE, 1'b0);
                    check("rst_rdy", u_if.CPU_RDY, 1'b1);
                end
                return;
            end
            prev_addr = u_if.BUS_ADDR;
            if (finished) break;
            if (do_inj) begin
                u_if.CPU_ADDR     = DMA_REG;
                u_if.CPU_RW_n     = 1'b0;
                u_if.CPU_DATA_OUT = 8'h07;
                do_inj = 0;
            end else begin
                idle_bus();
            end
            @(negedge clk);
        end
        check("finished", finished, 1'b1);
        check("n_writes", k, 256);
        check("stall_len", stall, exp_stall);
        check("done_pulses", dones, 1);
        if (page == 8'hFF) check("ff_last_wr", last_wdata, 8'h00);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rst_n = 1'b0;
        idle_bus();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_addr",  u_if.BUS_ADDR,     16'h0000);
        check("reset_rw",    u_if.BUS_RW_n,     1'b1);
        check("reset_wdata", u_if.BUS_DATA_OUT, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-triggering accesses: read of the DMA register, write next door.
        u_if.CPU_ADDR = DMA_REG; u_if.CPU_RW_n = 1'b1; u_if.CPU_DATA_OUT = 8'h02;
        @(negedge clk);
        check_idle_outputs("rd4014");
        u_if.CPU_ADDR = 16'h4015; u_if.CPU_RW_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("wr4015");
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle_outputs("no_trig");
        end

        run_dma(8'h02, 1'b0, -1, -1);     // even parity at HALT
        run_dma(8'h02, 1'b1, -1, -1);     // odd parity at HALT
        run_dma(8'h02, 1'b0, 8'h80, -1);  // retrigger mid-transfer ignored
        run_dma(8'h02, 1'b1, -1, 8'h40);  // reset mid-transfer
        run_dma(8'h02, 1'b0, -1, -1);     // fresh restart from idx 0

        for (int a = 0; a < 256; a++) mem[16'hFF00 + a] = ~8'(a);
        run_dma(8'hFF, 1'($urandom), -1, -1);

        for (int r = 0; r < 3; r++)
            run_dma(8'($urandom), 1'($urandom), -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
